// File: rtl/axi_rd_arb.sv
// Two-requester AXI read command arbiter with ARID-tagged response steering and outstanding-burst throttling.
// Build option: define AXI_RD_ARB_PRIO_EN for fixed priority (requester 0 wins); otherwise round-robin.
module axi_rd_arb #(
   parameter int unsigned ARID_WIDTH  = 4,
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter int unsigned RDATA_WIDTH = 64,
   parameter int unsigned MAX_OUTS    = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req0_arvld,
   input  logic [ADDR_WIDTH-1:0]  req0_araddr,
   input  logic [7:0]             req0_arlen,
   input  logic [2:0]             req0_arsize,
   input  logic [1:0]             req0_arburst,
   input  logic [2:0]             req0_arstr,
   input  logic [3:0]             req0_arnum,
   output logic                   req0_arrdy,
   output logic                   req0_rvld,
   output logic [RDATA_WIDTH-1:0] req0_rdata,
   output logic [1:0]             req0_rresp,
   output logic                   req0_rlast,
   input  logic                   req0_rrdy,
   input  logic                   req1_arvld,
   input  logic [ADDR_WIDTH-1:0]  req1_araddr,
   input  logic [7:0]             req1_arlen,
   input  logic [2:0]             req1_arsize,
   input  logic [1:0]             req1_arburst,
   input  logic [2:0]             req1_arstr,
   input  logic [3:0]             req1_arnum,
   output logic                   req1_arrdy,
   output logic                   req1_rvld,
   output logic [RDATA_WIDTH-1:0] req1_rdata,
   output logic [1:0]             req1_rresp,
   output logic                   req1_rlast,
   input  logic                   req1_rrdy,
   output logic                   lsu_axi_arvld,
   output logic [ARID_WIDTH-1:0]  lsu_axi_arid,
   output logic [ADDR_WIDTH-1:0]  lsu_axi_araddr,
   output logic [7:0]             lsu_axi_arlen,
   output logic [2:0]             lsu_axi_arsize,
   output logic [1:0]             lsu_axi_arburst,
   output logic [2:0]             lsu_axi_arstr,
   output logic [3:0]             lsu_axi_arnum,
   input  logic                   axi_lsu_arrdy,
   input  logic                   axi_lsu_rvld,
   input  logic [ARID_WIDTH-1:0]  axi_lsu_rid,
   input  logic [RDATA_WIDTH-1:0] axi_lsu_rdata,
   input  logic [1:0]             axi_lsu_rresp,
   input  logic                   axi_lsu_rlast,
   output logic                   lsu_axi_rrdy,
   output logic                   arb_err
);
   localparam int unsigned SEQ_W  = ARID_WIDTH - 1;
   localparam int unsigned OUTS_W = 4;
   localparam int unsigned SUM_W  = OUTS_W + 1;

   typedef enum logic {S_IDLE, S_ISSUE} state_t;

   state_t                  r_state, w_state_nxt;
   logic                    r_arvld;
   logic                    r_win;
   logic [ARID_WIDTH-1:0]   r_arid;
   logic [ADDR_WIDTH-1:0]   r_araddr;
   logic [7:0]              r_arlen;
   logic [2:0]              r_arsize;
   logic [1:0]              r_arburst;
   logic [2:0]              r_arstr;
   logic [3:0]              r_arnum;
   logic [SEQ_W-1:0]        r_seq [2];
   logic [OUTS_W-1:0]       r_outs [2];
   logic                    r_err;

   logic [1:0]              w_req_vld;
   logic [ADDR_WIDTH-1:0]   w_req_addr  [2];
   logic [7:0]              w_req_len   [2];
   logic [2:0]              w_req_size  [2];
   logic [1:0]              w_req_burst [2];
   logic [2:0]              w_req_str   [2];
   logic [3:0]              w_req_num   [2];
   logic [1:0]              w_elig;
   logic                    w_pick;
   logic                    w_load;
   logic                    w_accept;
   logic                    w_o;
   logic                    w_beat_last;
   logic                    w_err_set;
   logic [OUTS_W-1:0]       w_outs_nxt [2];
   logic                    w_rid_unused;

   assign w_req_vld      = {req1_arvld, req0_arvld};
   assign w_req_addr[0]  = req0_araddr;
   assign w_req_addr[1]  = req1_araddr;
   assign w_req_len[0]   = req0_arlen;
   assign w_req_len[1]   = req1_arlen;
   assign w_req_size[0]  = req0_arsize;
   assign w_req_size[1]  = req1_arsize;
   assign w_req_burst[0] = req0_arburst;
   assign w_req_burst[1] = req1_arburst;
   assign w_req_str[0]   = req0_arstr;
   assign w_req_str[1]   = req1_arstr;
   assign w_req_num[0]   = req0_arnum;
   assign w_req_num[1]   = req1_arnum;

   // A requester may issue only if the whole strided group fits under the outstanding limit.
   always_comb begin
      w_elig = '0;
      for (int n = 0; n < 2; n++) begin
         w_elig[n] = w_req_vld[n] &&
                     ((SUM_W'(r_outs[n]) + SUM_W'(w_req_num[n])) <= SUM_W'(MAX_OUTS));
      end
   end

`ifdef AXI_RD_ARB_PRIO_EN
   assign w_pick = ~w_elig[0];
`else
   logic r_last;

   assign w_pick = (&w_elig) ? ~r_last : w_elig[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_last <= 1'b1;
      else if (w_accept) r_last <= r_win;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|w_elig) begin
               w_load      = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (r_arvld && axi_lsu_arrdy) begin
               w_accept    = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Command register: captured on grant, held stable until the downstream handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arvld   <= 1'b0;
         r_win     <= 1'b0;
         r_arid    <= '0;
         r_araddr  <= '0;
         r_arlen   <= '0;
         r_arsize  <= '0;
         r_arburst <= '0;
         r_arstr   <= '0;
         r_arnum   <= '0;
      end else if (w_load) begin
         r_arvld   <= 1'b1;
         r_win     <= w_pick;
         r_arid    <= {w_pick, r_seq[w_pick]};
         r_araddr  <= w_req_addr[w_pick];
         r_arlen   <= w_req_len[w_pick];
         r_arsize  <= w_req_size[w_pick];
         r_arburst <= w_req_burst[w_pick];
         r_arstr   <= w_req_str[w_pick];
         r_arnum   <= w_req_num[w_pick];
      end else if (w_accept) begin
         r_arvld   <= 1'b0;
      end
   end

   assign w_o          = axi_lsu_rid[ARID_WIDTH-1];
   assign w_rid_unused = ^axi_lsu_rid[ARID_WIDTH-2:0];
   assign w_beat_last  = axi_lsu_rvld && lsu_axi_rrdy && axi_lsu_rlast;

   // Outstanding counters: add the accepted group, retire one burst per returned rlast.
   always_comb begin
      w_err_set = 1'b0;
      for (int n = 0; n < 2; n++) begin
         w_outs_nxt[n] = r_outs[n];
         if (w_accept && (r_win == 1'(n))) w_outs_nxt[n] = w_outs_nxt[n] + r_arnum;
         if (w_beat_last && (w_o == 1'(n))) begin
            if (r_outs[n] != '0) w_outs_nxt[n] = w_outs_nxt[n] - OUTS_W'(1);
            else                 w_err_set     = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_outs[0] <= '0;
         r_outs[1] <= '0;
         r_seq[0]  <= '0;
         r_seq[1]  <= '0;
         r_err     <= 1'b0;
      end else begin
         r_outs[0] <= w_outs_nxt[0];
         r_outs[1] <= w_outs_nxt[1];
         if (w_accept)  r_seq[r_win] <= r_seq[r_win] + SEQ_W'(1);
         if (w_err_set) r_err        <= 1'b1;
      end
   end

   assign req0_arrdy      = w_accept && !r_win;
   assign req1_arrdy      = w_accept &&  r_win;
   assign lsu_axi_arvld   = r_arvld;
   assign lsu_axi_arid    = r_arid;
   assign lsu_axi_araddr  = r_araddr;
   assign lsu_axi_arlen   = r_arlen;
   assign lsu_axi_arsize  = r_arsize;
   assign lsu_axi_arburst = r_arburst;
   assign lsu_axi_arstr   = r_arstr;
   assign lsu_axi_arnum   = r_arnum;
   assign arb_err         = r_err;

   // Beats steer purely on the ARID MSB; payload fans out to both requesters.
   assign req0_rvld    = axi_lsu_rvld && !w_o;
   assign req1_rvld    = axi_lsu_rvld &&  w_o;
   assign req0_rdata   = axi_lsu_rdata;
   assign req1_rdata   = axi_lsu_rdata;
   assign req0_rresp   = axi_lsu_rresp;
   assign req1_rresp   = axi_lsu_rresp;
   assign req0_rlast   = axi_lsu_rlast;
   assign req1_rlast   = axi_lsu_rlast;
   assign lsu_axi_rrdy = w_o ? req1_rrdy : req0_rrdy;

endmodule

// File: tb/tb_axi_rd_arb.sv
// Self-checking bench for axi_rd_arb: directed vector table, hand-written corner sequences,
// and a randomized run against a transaction-level reference model.
module tb_axi_rd_arb;
   localparam int unsigned AW   = 10;
   localparam int unsigned DW   = 64;
   localparam int unsigned IW   = 4;
   localparam int          MAXO = 8;
   localparam int          NSEQ = 8;

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    len;
      logic [2:0]    size;
      logic [1:0]    burst;
      logic [2:0]    str;
      logic [3:0]    num;
   } cmd_t;

   typedef struct {
      logic          v0, v1;
      logic [AW-1:0] a0, a1;
      logic          ardy;
      logic          e_vld;
      logic [IW-1:0] e_id;
      logic [AW-1:0] e_addr;
      logic          e_rdy0, e_rdy1;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   cmd_t rq [2];
   logic rq_v [2];
   logic ardy;
   logic rsp_vld, rsp_last;
   logic [IW-1:0] rsp_id;
   logic [DW-1:0] rsp_data;
   logic [1:0] rsp_resp;
   logic rrdy [2];

   logic req0_arrdy, req0_rvld, req0_rlast, req1_arrdy, req1_rvld, req1_rlast;
   logic [DW-1:0] req0_rdata, req1_rdata;
   logic [1:0] req0_rresp, req1_rresp;
   logic lsu_axi_arvld, lsu_axi_rrdy, arb_err;
   logic [IW-1:0] lsu_axi_arid;
   logic [AW-1:0] lsu_axi_araddr;
   logic [7:0] lsu_axi_arlen;
   logic [2:0] lsu_axi_arsize, lsu_axi_arstr;
   logic [1:0] lsu_axi_arburst;
   logic [3:0] lsu_axi_arnum;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   axi_rd_arb dut (
      .clk(clk), .rst_n(rst_n),
      .req0_arvld(rq_v[0]), .req0_araddr(rq[0].addr), .req0_arlen(rq[0].len),
      .req0_arsize(rq[0].size), .req0_arburst(rq[0].burst), .req0_arstr(rq[0].str),
      .req0_arnum(rq[0].num), .req0_arrdy(req0_arrdy), .req0_rvld(req0_rvld),
      .req0_rdata(req0_rdata), .req0_rresp(req0_rresp), .req0_rlast(req0_rlast),
      .req0_rrdy(rrdy[0]),
      .req1_arvld(rq_v[1]), .req1_araddr(rq[1].addr), .req1_arlen(rq[1].len),
      .req1_arsize(rq[1].size), .req1_arburst(rq[1].burst), .req1_arstr(rq[1].str),
      .req1_arnum(rq[1].num), .req1_arrdy(req1_arrdy), .req1_rvld(req1_rvld),
      .req1_rdata(req1_rdata), .req1_rresp(req1_rresp), .req1_rlast(req1_rlast),
      .req1_rrdy(rrdy[1]),
      .lsu_axi_arvld(lsu_axi_arvld), .lsu_axi_arid(lsu_axi_arid),
      .lsu_axi_araddr(lsu_axi_araddr), .lsu_axi_arlen(lsu_axi_arlen),
      .lsu_axi_arsize(lsu_axi_arsize), .lsu_axi_arburst(lsu_axi_arburst),
      .lsu_axi_arstr(lsu_axi_arstr), .lsu_axi_arnum(lsu_axi_arnum),
      .axi_lsu_arrdy(ardy), .axi_lsu_rvld(rsp_vld), .axi_lsu_rid(rsp_id),
      .axi_lsu_rdata(rsp_data), .axi_lsu_rresp(rsp_resp), .axi_lsu_rlast(rsp_last),
      .lsu_axi_rrdy(lsu_axi_rrdy), .arb_err(arb_err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic v0, input logic v1, input logic rdy,
                               input logic e_vld, input logic [IW-1:0] e_id,
                               input logic [AW-1:0] e_addr, input logic e0, input logic e1);
      vec_t r;
      r.v0 = v0; r.v1 = v1; r.a0 = 10'h040; r.a1 = 10'h200; r.ardy = rdy;
      r.e_vld = e_vld; r.e_id = e_id; r.e_addr = e_addr; r.e_rdy0 = e0; r.e_rdy1 = e1;
      return r;
   endfunction

   function automatic cmd_t rand_cmd();
      cmd_t c;
      c.addr  = AW'($urandom);
      c.len   = 8'($urandom);
      c.size  = 3'($urandom);
      c.burst = 2'($urandom);
      c.str   = 3'($urandom);
      c.num   = 4'($urandom_range(4, 1));
      return c;
   endfunction

   task automatic idle_inputs();
      rq_v[0] = 1'b0; rq_v[1] = 1'b0; ardy = 1'b0;
      rsp_vld = 1'b0; rsp_last = 1'b0; rsp_id = '0; rsp_data = '0; rsp_resp = '0;
      rrdy[0] = 1'b0; rrdy[1] = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Transaction-level reference state for the random run
   bit   m_vld, m_win, m_last, m_err;
   int   m_outs [2];
   int   m_seq  [2];
   int   m_id;
   cmd_t m_cmd;
   bit   drop [2];

   vec_t tbl [12];

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      rq[0] = '{10'h040, 8'd3, 3'd3, 2'd1, 3'd2, 4'd1};
      rq[1] = '{10'h200, 8'd7, 3'd2, 2'd1, 3'd5, 4'd1};

      // Reset state
      #12;
      chk("rst_arvld", 64'(lsu_axi_arvld), 64'(0));
      chk("rst_fields", 64'({lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arnum}), 64'(0));
      chk("rst_arrdy", 64'({req0_arrdy, req1_arrdy}), 64'(0));
      chk("rst_err", 64'(arb_err), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // Contention table: stall first, then both requesters hold arvld
      tbl[0] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 10'h000, 1'b0, 1'b0);
      tbl[1] = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 10'h040, 1'b0, 1'b0);
      tbl[2] = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 10'h040, 1'b1, 1'b0);
      tbl[3] = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 10'h000, 1'b0, 1'b0);
      tbl[5] = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 10'h000, 1'b0, 1'b0);
      tbl[7] = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 10'h000, 1'b0, 1'b0);
      tbl[9] = mk(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 10'h000, 1'b0, 1'b0);
      tbl[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 10'h000, 1'b0, 1'b0);
`ifdef AXI_RD_ARB_PRIO_EN
      tbl[4]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 10'h040, 1'b1, 1'b0);
      tbl[6]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h2, 10'h040, 1'b1, 1'b0);
      tbl[8]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 10'h040, 1'b1, 1'b0);
      tbl[10] = mk(1'b0, 1'b1, 1'b1, 1'b1, 4'h8, 10'h200, 1'b0, 1'b1);
`else
      tbl[4]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h8, 10'h200, 1'b0, 1'b1);
      tbl[6]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 10'h040, 1'b1, 1'b0);
      tbl[8]  = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'h9, 10'h200, 1'b0, 1'b1);
      tbl[10] = mk(1'b0, 1'b1, 1'b1, 1'b1, 4'hA, 10'h200, 1'b0, 1'b1);
`endif
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         rq_v[0] = tbl[i].v0; rq_v[1] = tbl[i].v1;
         rq[0].addr = tbl[i].a0; rq[1].addr = tbl[i].a1; ardy = tbl[i].ardy;
         #1;
         chk($sformatf("tbl%0d_arvld", i), 64'(lsu_axi_arvld), 64'(tbl[i].e_vld));
         chk($sformatf("tbl%0d_arrdy", i), 64'({req0_arrdy, req1_arrdy}),
             64'({tbl[i].e_rdy0, tbl[i].e_rdy1}));
         if (tbl[i].e_vld)
            chk($sformatf("tbl%0d_cmd", i), 64'({lsu_axi_arid, lsu_axi_araddr, lsu_axi_arnum}),
                64'({tbl[i].e_id, tbl[i].e_addr, 4'd1}));
      end

      // Throttle: req1 holds 6 outstanding, a 3-burst group must wait for one rlast
      do_reset();
      rq[1].addr = 10'h100; rq[1].num = 4'd6; rq_v[1] = 1'b1; ardy = 1'b1;
      #1 chk("thr_idle", 64'(lsu_axi_arvld), 64'(0));
      @(negedge clk); #1;
      chk("thr_cmd6", 64'({lsu_axi_arvld, lsu_axi_arid, lsu_axi_arnum, req1_arrdy}),
          64'({1'b1, 4'h8, 4'd6, 1'b1}));
      @(negedge clk);
      rq[1].addr = 10'h104; rq[1].num = 4'd3;
      for (int i = 0; i < 4; i++) begin
         #1 chk("thr_block", 64'(lsu_axi_arvld), 64'(0));
         @(negedge clk);
      end
      rsp_vld = 1'b1; rsp_id = 4'h8; rsp_last = 1'b1; rrdy[1] = 1'b1;
      #1 chk("thr_beat", 64'({req1_rvld, req0_rvld, lsu_axi_rrdy, lsu_axi_arvld}), 64'(4'b1010));
      @(negedge clk);
      rsp_vld = 1'b0; rsp_last = 1'b0;
      #1 chk("thr_idle2", 64'(lsu_axi_arvld), 64'(0));
      @(negedge clk); #1;
      chk("thr_grant", 64'({lsu_axi_arvld, lsu_axi_arid, lsu_axi_arnum, req1_arrdy}),
          64'({1'b1, 4'h9, 4'd3, 1'b1}));

      // Steering with backpressure: beat held 3 cycles, retires exactly one burst
      @(negedge clk);
      rq_v[1] = 1'b0; rrdy[0] = 1'b1; rrdy[1] = 1'b0;
      rsp_vld = 1'b1; rsp_id = 4'h9; rsp_last = 1'b1; rsp_data = 64'hDEAD_BEEF_0123_4567; rsp_resp = 2'd2;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("str_vld", 64'({req1_rvld, req0_rvld, lsu_axi_rrdy}), 64'(3'b100));
         chk("str_data", req1_rdata, 64'hDEAD_BEEF_0123_4567);
         chk("str_side", 64'({req0_rdata == rsp_data, req1_rresp, req1_rlast}), 64'({1'b1, 2'd2, 1'b1}));
         @(negedge clk);
      end
      rrdy[1] = 1'b1;
      #1 chk("str_rrdy", 64'(lsu_axi_rrdy), 64'(1));
      @(negedge clk);
      rsp_vld = 1'b0; rsp_last = 1'b0;
      rq[1].num = 4'd2; rq_v[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1 chk("str_outs7_block", 64'(lsu_axi_arvld), 64'(0));
      end
      rq_v[1] = 1'b0;
      @(negedge clk);
      rq[1].num = 4'd1; rq_v[1] = 1'b1;
      #1 chk("str_idle", 64'(lsu_axi_arvld), 64'(0));
      @(negedge clk); #1;
      chk("str_outs7_grant", 64'({lsu_axi_arvld, lsu_axi_arid, req1_arrdy}), 64'({1'b1, 4'hA, 1'b1}));

      // Stray rlast sets a sticky error
      @(negedge clk);
      rq_v[1] = 1'b0;
      rsp_vld = 1'b1; rsp_id = 4'h0; rsp_last = 1'b1; rrdy[0] = 1'b1;
      #1 chk("err_pre", 64'({arb_err, req0_rvld}), 64'(2'b01));
      @(negedge clk);
      rsp_vld = 1'b0; rsp_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("err_sticky", 64'(arb_err), 64'(1));
         @(negedge clk);
      end

      // Reset during ISSUE aborts the command immediately
      rq[0].num = 4'd1; rq_v[0] = 1'b1; ardy = 1'b0;
      @(negedge clk);
      #1 chk("rst_issue_vld", 64'(lsu_axi_arvld), 64'(1));
      @(negedge clk);
      ardy = 1'b1;
      #1 chk("rst_issue_rdy", 64'(req0_arrdy), 64'(1));
      #1 rst_n = 1'b0;
      #1 chk("rst_abort", 64'({lsu_axi_arvld, arb_err, req0_arrdy}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("rst_seq0", 64'({lsu_axi_arvld, lsu_axi_arid, req0_arrdy}), 64'({1'b1, 4'h0, 1'b1}));

      // Randomized run against the reference model
      do_reset();
      m_vld = 0; m_win = 0; m_last = 1; m_err = 0;
      m_outs = '{0, 0}; m_seq = '{0, 0}; drop = '{0, 0}; m_id = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         logic o;
         bit   acc, beat, el0, el1, w;
         int   nouts [2];
         logic e_r0, e_r1;
         @(negedge clk);
         for (int n = 0; n < 2; n++) begin
            if (drop[n]) begin rq_v[n] = 1'b0; drop[n] = 0; end
            if (!rq_v[n] && $urandom_range(1, 0) == 1) begin rq[n] = rand_cmd(); rq_v[n] = 1'b1; end
         end
         ardy     = ($urandom_range(3, 0) != 0);
         o        = 1'($urandom_range(1, 0));
         rsp_vld  = 1'($urandom_range(1, 0));
         rsp_id   = {o, 3'($urandom_range(7, 0))};
         rsp_last = (m_outs[o] > 0) && ($urandom_range(1, 0) == 1);
         rsp_data = {$urandom, $urandom};
         rsp_resp = 2'($urandom);
         rrdy[0]  = 1'($urandom_range(1, 0));
         rrdy[1]  = 1'($urandom_range(1, 0));
         #1;
         e_r0 = m_vld && ardy && !m_win;
         e_r1 = m_vld && ardy && m_win;
         chk("rnd_arvld", 64'(lsu_axi_arvld), 64'(m_vld));
         if (m_vld)
            chk("rnd_cmd", 64'({lsu_axi_arid, lsu_axi_araddr, lsu_axi_arlen, lsu_axi_arsize,
                                lsu_axi_arburst, lsu_axi_arstr, lsu_axi_arnum}),
                64'({4'(m_id), m_cmd.addr, m_cmd.len, m_cmd.size, m_cmd.burst, m_cmd.str, m_cmd.num}));
         chk("rnd_arrdy", 64'({req0_arrdy, req1_arrdy}), 64'({e_r0, e_r1}));
         chk("rnd_rvld", 64'({req0_rvld, req1_rvld}), 64'({rsp_vld && !o, rsp_vld && o}));
         chk("rnd_rrdy", 64'(lsu_axi_rrdy), 64'(rrdy[o]));
         chk("rnd_rdata", req0_rdata ^ req1_rdata ^ rsp_data, rsp_data);
         chk("rnd_rside", 64'({req0_rresp, req0_rlast, req1_rresp, req1_rlast}),
             64'({rsp_resp, rsp_last, rsp_resp, rsp_last}));
         chk("rnd_err", 64'(arb_err), 64'(m_err));

         acc   = m_vld && ardy;
         beat  = rsp_vld && rrdy[o] && rsp_last;
         nouts = m_outs;
         if (acc) nouts[m_win] += int'(m_cmd.num);
         if (beat) begin
            if (m_outs[o] > 0) nouts[o] -= 1;
            else               m_err = 1;
         end
         if (acc) begin
            m_seq[m_win] = (m_seq[m_win] + 1) % NSEQ;
            m_last       = m_win;
            m_vld        = 0;
            drop[m_win]  = 1;
         end else if (!m_vld) begin
            el0 = rq_v[0] && (m_outs[0] + int'(rq[0].num) <= MAXO);
            el1 = rq_v[1] && (m_outs[1] + int'(rq[1].num) <= MAXO);
            if (el0 || el1) begin
`ifdef AXI_RD_ARB_PRIO_EN
               w = !el0;
`else
               w = (el0 && el1) ? !m_last : el1;
`endif
               m_vld = 1; m_win = w; m_cmd = rq[w];
               m_id  = (w ? NSEQ : 0) + m_seq[w];
            end
         end
         m_outs = nouts;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
